// File: rtl/peri_req_arbiter.sv
// peri_req_arbiter: round-robin sequencer sharing the peripheral master
// (AXI-Lite bridge + CLINT) between the core LSU port (0) and the debug/DMA port (1).
// Ports: M_AXI_ACLK/M_AXI_ARESETN clock and async active-low reset.
//   Pn_REQ_* one-deep request slot per port; Pn_RESP_VALID/Pn_RDATA completion.
//   ADDR_TO_PERI_VALID/ADDR_TO_PERI/DATA_TO_PERI/WSTRB/WRITE_TO_PERI/PERI_WORD_ACCESS
//   are the held request bus; DATA_FROM_PERI_READY/DATA_FROM_PERI the completion.
//   GRANT_ID is the current/last owner; PERI_TIMEOUT is the sticky watchdog flag.
module peri_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TCNT_W         = 13
) (
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESETN,
    input  logic        P0_REQ_VALID,
    output logic        P0_REQ_READY,
    input  logic [63:0] P0_ADDR,
    input  logic [63:0] P0_WDATA,
    input  logic [7:0]  P0_WSTRB,
    input  logic        P0_WRITE,
    input  logic        P0_WORD_ACCESS,
    output logic        P0_RESP_VALID,
    output logic [63:0] P0_RDATA,
    input  logic        P1_REQ_VALID,
    output logic        P1_REQ_READY,
    input  logic [63:0] P1_ADDR,
    input  logic [63:0] P1_WDATA,
    input  logic [7:0]  P1_WSTRB,
    input  logic        P1_WRITE,
    input  logic        P1_WORD_ACCESS,
    output logic        P1_RESP_VALID,
    output logic [63:0] P1_RDATA,
    output logic        ADDR_TO_PERI_VALID,
    output logic [63:0] ADDR_TO_PERI,
    output logic [63:0] DATA_TO_PERI,
    output logic [7:0]  WSTRB,
    output logic        WRITE_TO_PERI,
    output logic        PERI_WORD_ACCESS,
    input  logic        DATA_FROM_PERI_READY,
    input  logic [63:0] DATA_FROM_PERI,
    output logic        GRANT_ID,
    output logic        PERI_TIMEOUT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t            r_state;
    logic [1:0]        r_pend;
    logic [63:0]       r_addr  [2];
    logic [63:0]       r_wdata [2];
    logic [7:0]        r_strb  [2];
    logic [1:0]        r_wr;
    logic [1:0]        r_word;
    logic [63:0]       r_rdata [2];
    logic [1:0]        r_resp;
    logic              r_last;
    logic              r_grant;
    logic              r_valid;
    logic [63:0]       r_bus_addr;
    logic [63:0]       r_bus_data;
    logic [7:0]        r_bus_strb;
    logic              r_bus_wr;
    logic              r_bus_word;
    logic [TCNT_W-1:0] r_cnt;
    logic              r_to;

    logic [63:0]       w_in_addr  [2];
    logic [63:0]       w_in_wdata [2];
    logic [7:0]        w_in_strb  [2];
    logic [1:0]        w_in_wr;
    logic [1:0]        w_in_word;
    logic [1:0]        w_acc;
    logic              w_own;
    logic [TCNT_W-1:0] w_cnt_nxt;
    logic              w_to_hit;

    assign w_in_addr[0]  = P0_ADDR;
    assign w_in_addr[1]  = P1_ADDR;
    assign w_in_wdata[0] = P0_WDATA;
    assign w_in_wdata[1] = P1_WDATA;
    assign w_in_strb[0]  = P0_WSTRB;
    assign w_in_strb[1]  = P1_WSTRB;
    assign w_in_wr       = {P1_WRITE, P0_WRITE};
    assign w_in_word     = {P1_WORD_ACCESS, P0_WORD_ACCESS};

    assign w_acc = {P1_REQ_VALID & ~r_pend[1], P0_REQ_VALID & ~r_pend[0]};

    // Both pending: the port that did not win last time; otherwise the sole one.
    assign w_own = (&r_pend) ? ~r_last : r_pend[1];

    assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_to_hit  = (TIMEOUT_CYCLES != 0) &&
                       (w_cnt_nxt == TCNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state    <= S_IDLE;
            r_pend     <= '0;
            r_wr       <= '0;
            r_word     <= '0;
            r_resp     <= '0;
            r_last     <= 1'b1;
            r_grant    <= 1'b0;
            r_valid    <= 1'b0;
            r_bus_addr <= '0;
            r_bus_data <= '0;
            r_bus_strb <= '0;
            r_bus_wr   <= 1'b0;
            r_bus_word <= 1'b0;
            r_cnt      <= '0;
            r_to       <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_addr[i]  <= '0;
                r_wdata[i] <= '0;
                r_strb[i]  <= '0;
                r_rdata[i] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            r_resp  <= '0;
            for (int i = 0; i < 2; i++) begin
                if (w_acc[i]) begin
                    r_addr[i]  <= w_in_addr[i];
                    r_wdata[i] <= w_in_wdata[i];
                    r_strb[i]  <= w_in_strb[i];
                    r_wr[i]    <= w_in_wr[i];
                    r_word[i]  <= w_in_word[i];
                    r_pend[i]  <= 1'b1;
                end
            end
            unique case (r_state)
                S_IDLE: begin
                    if (|r_pend) begin
                        r_bus_addr <= r_addr[w_own];
                        r_bus_data <= r_wdata[w_own];
                        r_bus_strb <= r_strb[w_own];
                        r_bus_wr   <= r_wr[w_own];
                        r_bus_word <= r_word[w_own];
                        r_grant    <= w_own;
                        r_last     <= w_own;
                        r_valid    <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_to_hit) begin
                        r_to <= 1'b1;
                    end
                    // Pending slot frees on the same edge the response is registered.
                    if (DATA_FROM_PERI_READY) begin
                        if (!r_bus_wr) begin
                            r_rdata[r_grant] <= DATA_FROM_PERI;
                        end
                        r_resp[r_grant] <= 1'b1;
                        r_pend[r_grant] <= 1'b0;
                        r_state         <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign P0_REQ_READY       = ~r_pend[0];
    assign P1_REQ_READY       = ~r_pend[1];
    assign P0_RESP_VALID      = r_resp[0];
    assign P1_RESP_VALID      = r_resp[1];
    assign P0_RDATA           = r_rdata[0];
    assign P1_RDATA           = r_rdata[1];
    assign ADDR_TO_PERI_VALID = r_valid;
    assign ADDR_TO_PERI       = r_bus_addr;
    assign DATA_TO_PERI       = r_bus_data;
    assign WSTRB              = r_bus_strb;
    assign WRITE_TO_PERI      = r_bus_wr;
    assign PERI_WORD_ACCESS   = r_bus_word;
    assign GRANT_ID           = r_grant;
    assign PERI_TIMEOUT       = r_to;

endmodule

// File: tb/tb_peri_req_arbiter.sv
// tb_peri_req_arbiter: randomized scoreboard bench for peri_req_arbiter.
// Driver, peripheral responder and monitor run as separate processes.
module tb_peri_req_arbiter;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        P0_REQ_VALID = 0, P1_REQ_VALID = 0;
    logic        P0_REQ_READY, P1_REQ_READY;
    logic [63:0] P0_ADDR = '0, P0_WDATA = '0, P1_ADDR = '0, P1_WDATA = '0;
    logic [7:0]  P0_WSTRB = '0, P1_WSTRB = '0;
    logic        P0_WRITE = 0, P0_WORD_ACCESS = 0, P1_WRITE = 0, P1_WORD_ACCESS = 0;
    logic        P0_RESP_VALID, P1_RESP_VALID;
    logic [63:0] P0_RDATA, P1_RDATA;
    logic        ADDR_TO_PERI_VALID;
    logic [63:0] ADDR_TO_PERI, DATA_TO_PERI;
    logic [7:0]  WSTRB;
    logic        WRITE_TO_PERI, PERI_WORD_ACCESS;
    logic        DATA_FROM_PERI_READY = 0;
    logic [63:0] DATA_FROM_PERI = '0;
    logic        GRANT_ID, PERI_TIMEOUT;

    always #5 clk = ~clk;

    peri_req_arbiter #(.TIMEOUT_CYCLES(T), .TCNT_W(13)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .P0_REQ_VALID(P0_REQ_VALID), .P0_REQ_READY(P0_REQ_READY),
        .P0_ADDR(P0_ADDR), .P0_WDATA(P0_WDATA), .P0_WSTRB(P0_WSTRB),
        .P0_WRITE(P0_WRITE), .P0_WORD_ACCESS(P0_WORD_ACCESS),
        .P0_RESP_VALID(P0_RESP_VALID), .P0_RDATA(P0_RDATA),
        .P1_REQ_VALID(P1_REQ_VALID), .P1_REQ_READY(P1_REQ_READY),
        .P1_ADDR(P1_ADDR), .P1_WDATA(P1_WDATA), .P1_WSTRB(P1_WSTRB),
        .P1_WRITE(P1_WRITE), .P1_WORD_ACCESS(P1_WORD_ACCESS),
        .P1_RESP_VALID(P1_RESP_VALID), .P1_RDATA(P1_RDATA),
        .ADDR_TO_PERI_VALID(ADDR_TO_PERI_VALID), .ADDR_TO_PERI(ADDR_TO_PERI),
        .DATA_TO_PERI(DATA_TO_PERI), .WSTRB(WSTRB),
        .WRITE_TO_PERI(WRITE_TO_PERI), .PERI_WORD_ACCESS(PERI_WORD_ACCESS),
        .DATA_FROM_PERI_READY(DATA_FROM_PERI_READY), .DATA_FROM_PERI(DATA_FROM_PERI),
        .GRANT_ID(GRANT_ID), .PERI_TIMEOUT(PERI_TIMEOUT)
    );

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic        wr;
        logic        word;
        int          hold;
        int          acc;
    } req_t;

    typedef struct {
        int          port;
        logic [63:0] rdata;
        int          cyc;
    } rsp_t;

    req_t todo0[$], todo1[$];
    req_t xq0[$], xq1[$];
    rsp_t rq[$];
    int   grants[$];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int n_resp = 0;

    // reference model state
    logic        m_last = 1'b1;
    logic        m_to = 1'b0;
    logic [63:0] m_rd [2];
    bit          infl = 0;
    int          g_cyc = 0;
    int          own = 0;
    req_t        cur;

    // test knobs
    int          rd_fixed = 0;
    bit          dfix_en = 0;
    logic [63:0] dfix = '0;
    bit          noise = 0;
    bit          chk_lat = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic add(int p, logic [63:0] a, logic [63:0] d,
                       logic [7:0] s, logic w, logic wd, int h);
        req_t r;
        r.addr = a; r.data = d; r.strb = s; r.wr = w; r.word = wd;
        r.hold = h; r.acc = 0;
        if (p == 0) todo0.push_back(r);
        else todo1.push_back(r);
    endtask

    task automatic chk_reset(string nm);
        chk({nm, "_valid"}, ADDR_TO_PERI_VALID, 0);
        chk({nm, "_addr"}, ADDR_TO_PERI, 0);
        chk({nm, "_data"}, DATA_TO_PERI, 0);
        chk({nm, "_flags"}, {WSTRB, WRITE_TO_PERI, PERI_WORD_ACCESS, GRANT_ID, PERI_TIMEOUT}, 0);
        chk({nm, "_resp"}, {P1_RESP_VALID, P0_RESP_VALID}, 0);
        chk({nm, "_rdata0"}, P0_RDATA, 0);
        chk({nm, "_rdata1"}, P1_RDATA, 0);
        chk({nm, "_ready"}, {P1_REQ_READY, P0_REQ_READY}, 2'b11);
    endtask

    task automatic wait_idle(string nm);
        int k = 0;
        while ((todo0.size() > 0 || todo1.size() > 0 || xq0.size() > 0 ||
                xq1.size() > 0 || infl || rq.size() > 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_drained"}, k < 3000, 1);
        repeat (2) @(negedge clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // request driver: offers a queued request only while the slot is empty
    always @(negedge clk) begin : drv
        req_t r;
        if (!rst_n) begin
            P0_REQ_VALID = 0;
            P1_REQ_VALID = 0;
            todo0.delete();
            todo1.delete();
        end else begin
            P0_REQ_VALID = 0;
            P1_REQ_VALID = 0;
            P0_ADDR = {$urandom, $urandom};
            P1_ADDR = {$urandom, $urandom};
            if (todo0.size() > 0) begin
                if (todo0[0].hold > 0) todo0[0].hold--;
                else if (P0_REQ_READY) begin
                    r = todo0.pop_front();
                    P0_ADDR = r.addr; P0_WDATA = r.data; P0_WSTRB = r.strb;
                    P0_WRITE = r.wr; P0_WORD_ACCESS = r.word; P0_REQ_VALID = 1;
                    r.acc = cyc + 1;
                    xq0.push_back(r);
                end
            end
            if (todo1.size() > 0) begin
                if (todo1[0].hold > 0) todo1[0].hold--;
                else if (P1_REQ_READY) begin
                    r = todo1.pop_front();
                    P1_ADDR = r.addr; P1_WDATA = r.data; P1_WSTRB = r.strb;
                    P1_WRITE = r.wr; P1_WORD_ACCESS = r.word; P1_REQ_VALID = 1;
                    r.acc = cyc + 1;
                    xq1.push_back(r);
                end
            end
        end
    end

    // peripheral master model; predicts the response it causes
    int rcnt = 0;
    always @(negedge clk) begin : rsp
        rsp_t e;
        if (!rst_n) begin
            rcnt = 0;
            DATA_FROM_PERI_READY = 0;
            m_rd[0] = '0;
            m_rd[1] = '0;
            rq.delete();
        end else begin
            DATA_FROM_PERI_READY = 0;
            DATA_FROM_PERI = {$urandom, $urandom};
            if (ADDR_TO_PERI_VALID) begin
                rcnt = (rd_fixed > 0) ? rd_fixed : int'($urandom_range(1, 8));
            end else if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    if (dfix_en) DATA_FROM_PERI = dfix;
                    DATA_FROM_PERI_READY = 1;
                    e.port = own;
                    e.rdata = cur.wr ? m_rd[own] : DATA_FROM_PERI;
                    e.cyc = cyc + 1;
                    m_rd[own] = e.rdata;
                    rq.push_back(e);
                end
            end else if (noise && $urandom_range(0, 7) == 0) begin
                DATA_FROM_PERI_READY = 1;
            end
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin : mon
        bit e0, e1;
        int o;
        logic [1:0] rv;
        rsp_t e;
        if (!rst_n) begin
            infl = 0;
            m_last = 1'b1;
            m_to = 1'b0;
            xq0.delete();
            xq1.delete();
        end else begin
            rv = {P1_RESP_VALID, P0_RESP_VALID};
            if (ADDR_TO_PERI_VALID) begin
                chk("valid_while_busy", infl, 0);
                e0 = xq0.size() > 0 && xq0[0].acc < cyc;
                e1 = xq1.size() > 0 && xq1[0].acc < cyc;
                chk("valid_has_request", e0 | e1, 1);
                if (e0 || e1) begin
                    o = (e0 && e1) ? (m_last ? 0 : 1) : (e1 ? 1 : 0);
                    cur = (o == 1) ? xq1.pop_front() : xq0.pop_front();
                    own = o;
                    m_last = o[0];
                    g_cyc = cyc;
                    infl = 1;
                    grants.push_back(o);
                    chk("grant_id", GRANT_ID, o);
                    chk("issue_addr", ADDR_TO_PERI, cur.addr);
                    chk("issue_data", DATA_TO_PERI, cur.data);
                    chk("issue_flags", {WSTRB, WRITE_TO_PERI, PERI_WORD_ACCESS},
                        {cur.strb, cur.wr, cur.word});
                    if (chk_lat) chk("issue_latency", cyc, cur.acc + 1);
                end
            end else if (infl && rv == 0) begin
                chk("hold_addr", ADDR_TO_PERI, cur.addr);
                chk("hold_data", DATA_TO_PERI, cur.data);
                chk("hold_flags", {WSTRB, WRITE_TO_PERI, PERI_WORD_ACCESS, GRANT_ID},
                    {cur.strb, cur.wr, cur.word, own[0]});
                chk("owner_ready_low", own ? P1_REQ_READY : P0_REQ_READY, 0);
            end
            if (infl && (cyc - g_cyc - 1) >= T) m_to = 1'b1;
            if (rv != 0) begin
                chk("resp_expected", rq.size() > 0, 1);
                if (rq.size() > 0) begin
                    e = rq.pop_front();
                    chk("resp_port", rv, (e.port == 1) ? 2'b10 : 2'b01);
                    chk("resp_cycle", cyc, e.cyc);
                    chk("resp_rdata", e.port ? P1_RDATA : P0_RDATA, e.rdata);
                    chk("other_rdata", e.port ? P0_RDATA : P1_RDATA,
                        e.port ? m_rd[0] : m_rd[1]);
                    n_resp++;
                end
                infl = 0;
            end
            chk("timeout_flag", PERI_TIMEOUT, m_to);
        end
    end

    initial begin : guard
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int base;
        int k;
        m_rd[0] = '0;
        m_rd[1] = '0;
        #1 rst_n = 0;
        #1 chk_reset("por");
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("por_ready_after", {P1_REQ_READY, P0_REQ_READY}, 2'b11);

        // single read
        rd_fixed = 3; dfix_en = 1; dfix = 64'h1122334455667788; chk_lat = 1;
        add(0, 64'hE0001000, 64'h0, 8'h00, 0, 0, 0);
        wait_idle("single");
        chk_lat = 0;
        chk("single_rdata", P0_RDATA, 64'h1122334455667788);
        chk("single_p1_silent", P1_RDATA, 0);
        chk("single_nresp", n_resp, 1);

        // simultaneous requests after a fresh reset
        @(posedge clk); #2 rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        grants.delete();
        dfix = 64'h0000_0001_2345_6789;
        add(0, 64'h02004000, 64'h55AA_55AA_0000_1111, 8'hFF, 1, 0, 0);
        add(1, 64'h0200BFF8, 64'h0, 8'h00, 0, 0, 0);
        wait_idle("simul");
        chk("simul_count", grants.size(), 2);
        if (grants.size() == 2) begin
            chk("simul_first", grants[0], 0);
            chk("simul_second", grants[1], 1);
        end
        chk("simul_mtime", P1_RDATA, 64'h0000_0001_2345_6789);
        chk("simul_p0_write_nodata", P0_RDATA, 0);

        // fairness
        grants.delete();
        rd_fixed = 2; dfix_en = 0;
        for (int i = 0; i < 3; i++) begin
            add(0, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 1'($urandom), 1'($urandom), 0);
            add(1, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 1'($urandom), 1'($urandom), 0);
        end
        wait_idle("fair");
        chk("fair_count", grants.size(), 6);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            chk("fair_seq", grants[i], i % 2);

        // randomized traffic with stray READY pulses outside WAIT
        base = n_resp;
        rd_fixed = 0; noise = 1;
        for (int i = 0; i < 40; i++)
            add(int'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 4)));
        wait_idle("random");
        noise = 0;
        chk("random_nresp", n_resp - base, 40);

        // watchdog
        base = n_resp;
        rd_fixed = 25;
        add(0, 64'hE0002000, 64'h0, 8'h00, 0, 1, 0);
        wait_idle("wdog");
        chk("wdog_sticky", PERI_TIMEOUT, 1);
        chk("wdog_resp_delivered", n_resp - base, 1);

        // stability with a long wait and a competing request
        grants.delete();
        rd_fixed = 20;
        add(1, 64'hE0001030, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1, 0, 0);
        add(0, 64'hE0001008, 64'h0, 8'h00, 0, 0, 4);
        wait_idle("stable");
        chk("stable_count", grants.size(), 2);
        if (grants.size() == 2) begin
            chk("stable_first", grants[0], 1);
            chk("stable_second", grants[1], 0);
        end
        chk("stable_timeout_kept", PERI_TIMEOUT, 1);

        // reset in the middle of WAIT
        rd_fixed = 10;
        add(0, 64'hE0003000, 64'h0, 8'h00, 0, 0, 0);
        k = 0;
        while (!infl && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("mid_issue_seen", infl, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst_n = 0;
        #1 chk_reset("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            chk("midrst_no_resp", {P1_RESP_VALID, P0_RESP_VALID}, 0);
            chk("midrst_ready", {P1_REQ_READY, P0_REQ_READY}, 2'b11);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
